// File: rtl/io_pad_pkg.sv
// Shared types and constants for input-direction pad tiles.
package io_pad_pkg;

    // Debounce FSM: two stable levels plus one pending state toward each level.
    typedef enum logic [1:0] {
        StStableLo = 2'd0,
        StPendHi   = 2'd1,
        StStableHi = 2'd2,
        StPendLo   = 2'd3
    } io_pad_state_e;

    localparam int unsigned IO_SYNC_STAGES_DEF = 2;
    localparam int unsigned IO_DEBOUNCE_DEF    = 4;

    // Encoding of the held event type.
    localparam logic EVT_FALL = 1'b0;
    localparam logic EVT_RISE = 1'b1;

endpackage

// File: rtl/io_pad_sync.sv
// Multi-flop synchronizer for an asynchronous pad level; no logic between stages.
module io_pad_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VALUE = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift the raw level through the flop chain; index 0 samples the pad.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {SYNC_STAGES{RESET_VALUE}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/logical_tile_io_input_pad_conditioner.sv
// Input pad conditioner: synchronize, debounce, emit edge pulses and hold a sticky edge event.
module logical_tile_io_input_pad_conditioner
    import io_pad_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = IO_SYNC_STAGES_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = IO_DEBOUNCE_DEF,
    parameter logic        RESET_VALUE     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic gfpga_pad_GPIN_PAD,
    input  logic cfg_bypass,
    output logic iopad_inpad,
    output logic iopad_rise,
    output logic iopad_fall,
    output logic evt_valid,
    output logic evt_edge,
    output logic evt_overrun,
    input  logic evt_ack
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntTerm = CntW'(DEBOUNCE_CYCLES);
    localparam io_pad_state_e StReset = RESET_VALUE ? StStableHi : StStableLo;

    logic s;

    io_pad_sync #(
        .SYNC_STAGES(SYNC_STAGES),
        .RESET_VALUE(RESET_VALUE)
    ) u_sync (
        .clk_i(clk),
        .rst_i(reset),
        .d_i  (gfpga_pad_GPIN_PAD),
        .q_o  (s)
    );

    io_pad_state_e   state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
    logic            inpad_q, inpad_d;
    logic            rise_q, rise_d, fall_q, fall_d;
    logic            valid_q, valid_d, edge_q, edge_d, ovr_q, ovr_d;
    logic            fast_commit;

    assign cnt_inc     = cnt_q + CntW'(1);
    assign fast_commit = (DEBOUNCE_CYCLES == 1) || cfg_bypass;

    // Debounce next-state: a level is committed only after CntTerm consecutive new samples.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        inpad_d = inpad_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            StStableLo: begin
                if (s) begin
                    if (fast_commit) begin
                        state_d = StStableHi;
                        inpad_d = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = StPendHi;
                        cnt_d   = CntW'(1);
                    end
                end
            end
            StPendHi: begin
                if (!s) begin
                    state_d = StStableLo;
                    cnt_d   = '0;
                end else if (cnt_inc == CntTerm || cfg_bypass) begin
                    state_d = StStableHi;
                    cnt_d   = '0;
                    inpad_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StStableHi: begin
                if (!s) begin
                    if (fast_commit) begin
                        state_d = StStableLo;
                        inpad_d = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        state_d = StPendLo;
                        cnt_d   = CntW'(1);
                    end
                end
            end
            StPendLo: begin
                if (s) begin
                    state_d = StStableHi;
                    cnt_d   = '0;
                end else if (cnt_inc == CntTerm || cfg_bypass) begin
                    state_d = StStableLo;
                    cnt_d   = '0;
                    inpad_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = StReset;
                cnt_d   = '0;
            end
        endcase
    end

    // Sticky event register; the edge being committed this cycle is what gets captured.
    always_comb begin
        valid_d = valid_q;
        edge_d  = edge_q;
        ovr_d   = ovr_q;
        if (rise_d || fall_d) begin
            if (!valid_q || evt_ack) begin
                valid_d = 1'b1;
                edge_d  = rise_d ? EVT_RISE : EVT_FALL;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && evt_ack) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    // State and output registers; reset discards any pending change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StReset;
            cnt_q   <= '0;
            inpad_q <= RESET_VALUE;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            valid_q <= 1'b0;
            edge_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            inpad_q <= inpad_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            valid_q <= valid_d;
            edge_q  <= edge_d;
            ovr_q   <= ovr_d;
        end
    end

    assign iopad_inpad = inpad_q;
    assign iopad_rise  = rise_q;
    assign iopad_fall  = fall_q;
    assign evt_valid   = valid_q;
    assign evt_edge    = edge_q;
    assign evt_overrun = ovr_q;

endmodule

// File: tb/tb_logical_tile_io_input_pad_conditioner.sv
// Scoreboard bench: a run-length reference model predicts every output cycle.
module tb_logical_tile_io_input_pad_conditioner;

    localparam int unsigned SYNC = 2;
    localparam int unsigned DEB  = 4;
    localparam logic        RV   = 1'b0;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic pad = 1'b0;
    logic byp = 1'b0;
    logic ack = 1'b0;
    logic inpad, rise, fall, valid, edge_o, ovr;

    int checks = 0;
    int failures = 0;
    int cycle = 0;

    logic [5:0] exp_q[$];

    // Reference model state.
    bit hist[$];
    bit m_level, m_rise, m_fall, m_valid, m_edge, m_ovr;
    int run;

    logical_tile_io_input_pad_conditioner #(
        .SYNC_STAGES(SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .RESET_VALUE(RV)
    ) dut (
        .clk(clk),
        .reset(reset),
        .gfpga_pad_GPIN_PAD(pad),
        .cfg_bypass(byp),
        .iopad_inpad(inpad),
        .iopad_rise(rise),
        .iopad_fall(fall),
        .evt_valid(valid),
        .evt_edge(edge_o),
        .evt_overrun(ovr),
        .evt_ack(ack)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        hist = {};
        for (int i = 0; i < SYNC; i++) hist.push_back(RV);
        m_level = RV;
        run = 0;
        m_rise = 0;
        m_fall = 0;
        m_valid = 0;
        m_edge = 0;
        m_ovr = 0;
    endtask

    // One clock edge: s is the pad as sampled SYNC edges ago; commit after DEB differing samples.
    task automatic model_step(input bit p, input bit b, input bit a);
        bit s, e;
        s = hist.pop_front();
        hist.push_back(p);
        m_rise = 0;
        m_fall = 0;
        if (s != m_level) run++;
        else run = 0;
        if (run > 0 && (run >= DEB || b)) begin
            m_level = s;
            run = 0;
            if (s) m_rise = 1;
            else m_fall = 1;
        end
        e = m_rise | m_fall;
        if (e && (!m_valid || a)) begin
            m_valid = 1;
            m_edge = m_rise;
        end else if (e) begin
            m_ovr = 1;
        end else if (m_valid && a) begin
            m_valid = 0;
            m_ovr = 0;
        end
    endtask

    // Model: predict outputs after every clock edge or asynchronous reset assertion.
    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else model_step(pad, byp, ack);
        exp_q.push_back({m_level, m_rise, m_fall, m_valid, m_edge, m_ovr});
    end

    // Monitor: sample just after the event and compare against the oldest prediction.
    always @(posedge clk or posedge reset) begin
        logic [5:0] got, exp;
        #1;
        cycle++;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            got = {inpad, rise, fall, valid, edge_o, ovr};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL outputs cycle=%0d {inpad,rise,fall,valid,edge,ovr} got=%b expected=%b",
                         cycle, got, exp);
            end
        end
    end

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1;
        // Reset with pad already high; release and let it debounce.
        reset = 1'b1;
        pad = 1'b1;
        hold(3);
        reset = 1'b0;
        hold(10);
        // Fall commits on edge 6 while ack is given on a held rise.
        pad = 1'b0;
        hold(5);
        ack = 1'b1;
        hold(1);
        ack = 1'b0;
        hold(4);
        ack = 1'b1;
        hold(1);
        ack = 1'b0;
        // Rise then fall without ack: overrun, then one ack clears.
        pad = 1'b1;
        hold(8);
        pad = 1'b0;
        hold(8);
        ack = 1'b1;
        hold(1);
        ack = 1'b0;
        hold(2);
        // Glitch of three cycles is rejected.
        pad = 1'b1;
        hold(3);
        pad = 1'b0;
        hold(8);
        // Bypass: commits SYNC+1 edges after the change.
        byp = 1'b1;
        pad = 1'b1;
        hold(5);
        pad = 1'b0;
        hold(5);
        byp = 1'b0;
        // Reset asserted mid-debounce, pad stays high afterwards.
        pad = 1'b1;
        hold(4);
        reset = 1'b1;
        hold(2);
        reset = 1'b0;
        hold(10);
        // Randomized segments of varying length, bypass and ack.
        for (int seg = 0; seg < 60; seg++) begin
            int len;
            pad = ~pad;
            len = $urandom_range(1, 9);
            if ($urandom_range(0, 3) == 0) byp = ~byp;
            for (int k = 0; k < len; k++) begin
                ack = ($urandom_range(0, 2) == 0);
                if (seg == 30 && k == 0) reset = 1'b1;
                else reset = 1'b0;
                @(negedge clk);
            end
        end
        reset = 1'b0;
        ack = 1'b0;
        hold(12);
        if (checks < 200) begin
            failures++;
            $display("FAIL check_count got=%0d required_at_least=200", checks);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
